// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: instruction decode fields,
// FSM state encoding and the exception status codes written to the status register.
package multdiv_sequencer_pkg;

    localparam logic [4:0] OPCODE_ALU = 5'b00000;
    localparam logic [4:0] ALUOP_MUL  = 5'b00110;
    localparam logic [4:0] ALUOP_DIV  = 5'b00111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] EXC_CODE_MULT = 32'd4;
    localparam logic [31:0] EXC_CODE_DIV  = 32'd5;

    localparam int COUNT_WIDTH = 6;

    typedef struct packed {
        logic       is_mult;
        logic       is_div;
        logic [4:0] rd;
    } md_decode_t;

    function automatic md_decode_t decode_ir(input logic [31:0] ir);
        md_decode_t d;
        d.is_mult = (ir[31:27] == OPCODE_ALU) && (ir[6:2] == ALUOP_MUL);
        d.is_div  = (ir[31:27] == OPCODE_ALU) && (ir[6:2] == ALUOP_DIV);
        d.rd      = ir[26:22];
        return d;
    endfunction

endpackage

// File: rtl/multdiv_sequencer_timeout_counter.sv
// Cycle counter for an in-flight mult/div; flags the cycle in which the
// operation has run out of its allotted time.
module md_timeout_counter
    import multdiv_sequencer_pkg::*;
#(
    parameter int LIMIT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(LIMIT - 1);

    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Counting the current cycle would bring the total up to LIMIT.
    assign terminal = enable && (count == LAST_COUNT);

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues mult/div instructions to an iterative unit, stalls the pipeline while it
// runs, and produces a one-cycle write-back of the result or an exception status.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int TIMEOUT     = 40,
    parameter int RSTATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir,
    input  logic [31:0] dx_a,
    input  logic [31:0] dx_b,
    input  logic        issue_kill,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] md_op_a,
    output logic [31:0] md_op_b,
    output logic        mult_running,
    output logic        div_running,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam logic [4:0] RSTATUS_RD = 5'(RSTATUS_REG);

    logic [1:0]  state;
    md_decode_t  dec;
    logic        issue_ok;
    logic        counting;
    logic        timed_out;
    logic [4:0]  op_rd;
    logic        op_is_div;
    logic [31:0] result_q;
    logic        exc_q;
    logic        unused_ir;

    assign dec       = decode_ir(dx_ir);
    assign unused_ir = ^{dx_ir[21:7], dx_ir[1:0]};

    // Start pulses are combinational so issue, operand latch and start share a cycle.
    assign issue_ok  = reset && (state == ST_IDLE) && !issue_kill;
    assign ctrl_mult = issue_ok && dec.is_mult;
    assign ctrl_div  = issue_ok && dec.is_div;

    assign mult_running = (state == ST_MULT);
    assign div_running  = (state == ST_DIV);
    assign counting     = mult_running || div_running;

    md_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (ctrl_mult || ctrl_div),
        .enable   (counting && !md_ready),
        .terminal (timed_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            md_op_a   <= '0;
            md_op_b   <= '0;
            op_rd     <= '0;
            op_is_div <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_mult || ctrl_div) begin
                        md_op_a   <= dx_a;
                        md_op_b   <= dx_b;
                        op_rd     <= dec.rd;
                        op_is_div <= ctrl_div;
                        exc_q     <= 1'b0;
                        state     <= ctrl_div ? ST_DIV : ST_MULT;
                    end
                end
                ST_MULT, ST_DIV: begin
                    // A ready pulse in the timeout cycle still delivers its result.
                    if (md_ready) begin
                        result_q <= md_result;
                        exc_q    <= md_exception;
                        state    <= ST_DONE;
                    end else if (timed_out) begin
                        exc_q <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Exceptions always report to the status register; a clean result to r0 is dropped.
    always_comb begin
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        if (state == ST_DONE) begin
            if (exc_q) begin
                wb_valid = 1'b1;
                wb_rd    = RSTATUS_RD;
                wb_data  = op_is_div ? EXC_CODE_DIV : EXC_CODE_MULT;
            end else if (op_rd != 5'd0) begin
                wb_valid = 1'b1;
                wb_rd    = op_rd;
                wb_data  = result_q;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: a transaction-level reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_multdiv_sequencer;

    localparam int TIMEOUT     = 40;
    localparam int RSTATUS_REG = 30;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dx_ir = '0;
    logic [31:0] dx_a = '0;
    logic [31:0] dx_b = '0;
    logic        issue_kill = 1'b0;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_ready = 1'b0;
    logic        ctrl_mult, ctrl_div, mult_running, div_running, wb_valid;
    logic [31:0] md_op_a, md_op_b, wb_data;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;

    int n_ctrl_mult = 0;
    int n_ctrl_div  = 0;
    int n_mult_run  = 0;
    int n_div_run   = 0;
    int n_wb        = 0;

    multdiv_sequencer #(
        .TIMEOUT     (TIMEOUT),
        .RSTATUS_REG (RSTATUS_REG)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dx_ir        (dx_ir),
        .dx_a         (dx_a),
        .dx_b         (dx_b),
        .issue_kill   (issue_kill),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_ready     (md_ready),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .md_op_a      (md_op_a),
        .md_op_b      (md_op_b),
        .mult_running (mult_running),
        .div_running  (div_running),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] make_ir(input logic [4:0] aluop, input logic [4:0] rd);
        logic [31:0] ir;
        ir       = '0;
        ir[26:22] = rd;
        ir[6:2]  = aluop;
        return ir;
    endfunction

    task automatic apply_stimulus(input logic [31:0] ir, input logic [31:0] a,
                                  input logic [31:0] b, input logic kill);
        dx_ir      = ir;
        dx_a       = a;
        dx_b       = b;
        issue_kill = kill;
    endtask

    task automatic set_ready(input logic rdy, input logic exc, input logic [31:0] res);
        md_ready     = rdy;
        md_exception = exc;
        md_result    = res;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: one outstanding operation, its elapsed cycles, and a pending write-back.
    logic        m_busy = 1'b0;
    logic        m_div = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    int          m_waited = 0;
    logic        m_wb_pend = 1'b0;
    logic        m_wb_valid = 1'b0;
    logic [4:0]  m_wb_rd = '0;
    logic [31:0] m_wb_data = '0;

    always @(negedge clock) begin
        logic is_m, is_d, idle, e_cm, e_cd, e_wb;
        n_ctrl_mult += int'(ctrl_mult);
        n_ctrl_div  += int'(ctrl_div);
        n_mult_run  += int'(mult_running);
        n_div_run   += int'(div_running);
        n_wb        += int'(wb_valid);
        if (!reset) begin
            m_busy    = 1'b0;
            m_wb_pend = 1'b0;
            m_a       = '0;
            m_b       = '0;
            check_output("reset ctrl_mult", 32'(ctrl_mult), 32'd0);
            check_output("reset ctrl_div", 32'(ctrl_div), 32'd0);
            check_output("reset mult_running", 32'(mult_running), 32'd0);
            check_output("reset div_running", 32'(div_running), 32'd0);
            check_output("reset md_op_a", md_op_a, 32'd0);
            check_output("reset md_op_b", md_op_b, 32'd0);
            check_output("reset wb_valid", 32'(wb_valid), 32'd0);
            check_output("reset wb_rd", 32'(wb_rd), 32'd0);
            check_output("reset wb_data", wb_data, 32'd0);
        end else begin
            is_m = (dx_ir[31:27] == 5'd0) && (dx_ir[6:2] == OP_MUL);
            is_d = (dx_ir[31:27] == 5'd0) && (dx_ir[6:2] == OP_DIV);
            idle = !m_busy && !m_wb_pend;
            e_cm = idle && is_m && !issue_kill;
            e_cd = idle && is_d && !issue_kill;
            e_wb = m_wb_pend && m_wb_valid;
            check_output("ctrl_mult", 32'(ctrl_mult), 32'(e_cm));
            check_output("ctrl_div", 32'(ctrl_div), 32'(e_cd));
            check_output("mult_running", 32'(mult_running), 32'(m_busy && !m_div));
            check_output("div_running", 32'(div_running), 32'(m_busy && m_div));
            check_output("md_op_a", md_op_a, m_a);
            check_output("md_op_b", md_op_b, m_b);
            check_output("wb_valid", 32'(wb_valid), 32'(e_wb));
            if (e_wb) begin
                check_output("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
                check_output("wb_data", wb_data, m_wb_data);
            end
            if (m_wb_pend) begin
                m_wb_pend = 1'b0;
            end else if (m_busy) begin
                m_waited++;
                if (md_ready || m_waited == TIMEOUT) begin
                    m_busy    = 1'b0;
                    m_wb_pend = 1'b1;
                    if (!md_ready || md_exception) begin
                        m_wb_valid = 1'b1;
                        m_wb_rd    = 5'(RSTATUS_REG);
                        m_wb_data  = m_div ? 32'd5 : 32'd4;
                    end else begin
                        m_wb_valid = (m_rd != 5'd0);
                        m_wb_rd    = m_rd;
                        m_wb_data  = md_result;
                    end
                end
            end else if (e_cm || e_cd) begin
                m_busy   = 1'b1;
                m_div    = e_cd;
                m_rd     = dx_ir[26:22];
                m_a      = dx_a;
                m_b      = dx_b;
                m_waited = 0;
            end
        end
    end

    initial begin
        int base_cm, base_mr, base_wb;

        $display("[TB] reset state");
        apply_stimulus(32'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check_output("lit reset mult_running", 32'(mult_running), 32'd0);
        check_output("lit reset wb_rd", 32'(wb_rd), 32'd0);
        reset = 1'b1;

        $display("[TB] mult r3 = 7*6 after 32 cycles");
        base_cm = n_ctrl_mult; base_mr = n_mult_run; base_wb = n_wb;
        apply_stimulus(make_ir(OP_MUL, 5'd3), 32'd7, 32'd6, 1'b0);
        #1 check_output("lit issue ctrl_mult", 32'(ctrl_mult), 32'd1);
        step();
        check_output("lit md_op_a", md_op_a, 32'd7);
        check_output("lit md_op_b", md_op_b, 32'd6);
        repeat (31) step();
        set_ready(1'b1, 1'b0, 32'd42);
        step();
        set_ready(1'b0, 1'b0, 32'd0);
        #1;
        check_output("lit mult wb_valid", 32'(wb_valid), 32'd1);
        check_output("lit mult wb_rd", 32'(wb_rd), 32'd3);
        check_output("lit mult wb_data", wb_data, 32'd42);
        step();

        $display("[TB] div r5 right after DONE, exception");
        apply_stimulus(make_ir(OP_DIV, 5'd5), 32'd100, 32'd7, 1'b0);
        #1 check_output("lit ctrl_div after DONE", 32'(ctrl_div), 32'd1);
        check_output("lit ctrl_mult pulses", 32'(n_ctrl_mult - base_cm), 32'd1);
        check_output("lit mult_running cycles", 32'(n_mult_run - base_mr), 32'd32);
        check_output("lit mult wb count", 32'(n_wb - base_wb), 32'd1);
        step();
        repeat (9) step();
        set_ready(1'b1, 1'b1, 32'd123);
        step();
        set_ready(1'b0, 1'b0, 32'd0);
        #1;
        check_output("lit div exc wb_rd", 32'(wb_rd), 32'd30);
        check_output("lit div exc wb_data", wb_data, 32'd5);
        step();
        apply_stimulus(32'd0, 32'd0, 32'd0, 1'b0);

        $display("[TB] mult timeout, stray div decode, late ready");
        step();
        base_mr = n_mult_run; base_wb = n_wb;
        apply_stimulus(make_ir(OP_MUL, 5'd7), 32'd3, 32'd4, 1'b0);
        step();
        repeat (4) step();
        apply_stimulus(make_ir(OP_DIV, 5'd8), 32'd9, 32'd9, 1'b0);
        #1 check_output("lit div ignored while busy", 32'(ctrl_div), 32'd0);
        repeat (3) step();
        apply_stimulus(make_ir(OP_MUL, 5'd7), 32'd3, 32'd4, 1'b0);
        repeat (32) step();
        #1 check_output("lit cycle 40 running", 32'(mult_running), 32'd1);
        step();
        set_ready(1'b1, 1'b0, 32'd99);
        #1;
        check_output("lit timeout wb_rd", 32'(wb_rd), 32'd30);
        check_output("lit timeout wb_data", wb_data, 32'd4);
        step();
        apply_stimulus(32'd0, 32'd0, 32'd0, 1'b0);
        step();
        set_ready(1'b0, 1'b0, 32'd0);
        check_output("lit timeout running cycles", 32'(n_mult_run - base_mr), 32'd40);
        check_output("lit timeout wb count", 32'(n_wb - base_wb), 32'd1);

        $display("[TB] ready coincides with timeout");
        apply_stimulus(make_ir(OP_MUL, 5'd9), 32'd1, 32'd2, 1'b0);
        step();
        repeat (39) step();
        set_ready(1'b1, 1'b0, 32'd77);
        step();
        set_ready(1'b0, 1'b0, 32'd0);
        #1;
        check_output("lit tie wb_rd", 32'(wb_rd), 32'd9);
        check_output("lit tie wb_data", wb_data, 32'd77);
        step();
        apply_stimulus(32'd0, 32'd0, 32'd0, 1'b0);

        $display("[TB] mult to r0, ready on issue cycle");
        apply_stimulus(make_ir(OP_MUL, 5'd0), 32'd3, 32'd3, 1'b0);
        set_ready(1'b1, 1'b0, 32'd55);
        step();
        set_ready(1'b0, 1'b0, 32'd0);
        #1 check_output("lit issue-cycle ready ignored", 32'(mult_running), 32'd1);
        repeat (4) step();
        set_ready(1'b1, 1'b0, 32'd9);
        step();
        set_ready(1'b0, 1'b0, 32'd0);
        #1 check_output("lit r0 wb_valid", 32'(wb_valid), 32'd0);
        step();
        apply_stimulus(32'd0, 32'd0, 32'd0, 1'b0);

        $display("[TB] killed mult");
        apply_stimulus(make_ir(OP_MUL, 5'd2), 32'd5, 32'd5, 1'b1);
        #1 check_output("lit kill ctrl_mult", 32'(ctrl_mult), 32'd0);
        step();
        #1 check_output("lit kill stays idle", 32'(mult_running), 32'd0);
        apply_stimulus(32'd0, 32'd0, 32'd0, 1'b0);
        step();

        $display("[TB] reset in the middle of a div");
        base_wb = n_wb;
        apply_stimulus(make_ir(OP_DIV, 5'd6), 32'd11, 32'd12, 1'b0);
        step();
        repeat (9) step();
        reset = 1'b0;
        #1;
        check_output("lit async reset div_running", 32'(div_running), 32'd0);
        check_output("lit async reset ctrl_div", 32'(ctrl_div), 32'd0);
        check_output("lit async reset md_op_a", md_op_a, 32'd0);
        step();
        step();
        reset = 1'b1;
        apply_stimulus(make_ir(OP_MUL, 5'd4), 32'd2, 32'd3, 1'b0);
        #1 check_output("lit post-reset ctrl_mult", 32'(ctrl_mult), 32'd1);
        step();
        repeat (2) step();
        set_ready(1'b1, 1'b0, 32'd6);
        step();
        set_ready(1'b0, 1'b0, 32'd0);
        #1;
        check_output("lit post-reset wb_rd", 32'(wb_rd), 32'd4);
        check_output("lit post-reset wb_data", wb_data, 32'd6);
        step();
        apply_stimulus(32'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) step();
        check_output("lit reset discards div wb", 32'(n_wb - base_wb), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
